// File: rtl/sw_pkg.sv
// Shared constants and helpers for the switch debounce stage.
// Default sizing matches the 4-bit register pipeline board.
package sw_pkg;

  localparam int SW_WIDTH        = 4;
  localparam int SW_TICK_DIV     = 125000;
  localparam int SW_STABLE_TICKS = 10;

  // Counter must hold 0..STABLE_TICKS-1 plus headroom for the compare.
  function automatic int cnt_w(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: registered one-cycle tick every TICK_DIV clocks.
// Used as the clock enable for the debounce counters and similar blocks.
module tick_gen #(
  parameter int TICK_DIV = 125000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    tick_d = (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning: 2-flop sync + per-bit tick-based stability filter.
// Define SW_DEBOUNCE_EDGE_EN to add per-bit rise/fall pulse outputs.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = SW_TICK_DIV,
  parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] d_out,
  output logic             changed,
  output logic             tick
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int CW = cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] upd;
  logic             chg_q, chg_d;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ;

    assign differ = (s2_q[i] != d_q[i]);
    assign upd[i] = differ && tick && (cnt_q == CMAX);

    // Any cycle back at the accepted level restarts the hold count.
    always_comb begin
      cnt_d = cnt_q;
      if (!differ || upd[i]) cnt_d = '0;
      else if (tick)         cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

  always_comb begin
    d_d   = d_q ^ upd;
    chg_d = |upd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      chg_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      chg_q <= chg_d;
    end
  end

  assign d_out   = d_q;
  assign changed = chg_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & s2_q;
      fall_q <= upd & ~s2_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  // Without edge outputs, changed alone marks an update.
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce (TICK_DIV=4, STABLE_TICKS=3).
// Build with SW_DEBOUNCE_EDGE_EN to also check rise/fall pulses.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] d_out;
  logic       changed;
  logic       tick;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [3:0] rise, fall;
`endif

  sw_debounce #(
    .WIDTH       (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw_raw (sw_raw),
    .d_out  (d_out),
    .changed(changed),
    .tick   (tick)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .rise   (rise),
    .fall   (fall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    int         t0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] last = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    exp_t e;
    e.val = v;
    e.t0  = cyc;
    q.push_back(e);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  // Output monitor: every changed pulse must match the next queued update.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      last = '0;
    end else if (changed) begin
      if (q.size() == 0) begin
        chk("spurious_changed", changed, 0);
      end else begin
        exp_t e;
        int   lat;
        e   = q.pop_front();
        lat = cyc - 1 - e.t0;
        chk("d_out", d_out, e.val);
        chk("latency_11_14", (lat >= 11 && lat <= 14), 1);
`ifdef SW_DEBOUNCE_EDGE_EN
        chk("rise", rise, e.val & ~last);
        chk("fall", fall, ~e.val & last);
`endif
        last = e.val;
      end
    end else begin
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("edge_idle", {rise, fall}, 0);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    sw_raw = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_d_out", d_out, 0);
    chk("rst_changed", changed, 0);
    chk("rst_tick", tick, 0);

    sw_raw = 4'h0;
    rst_n  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("tick_phase", tick, (k % 4) == 0);
    end

    // clean step
    push(4'h5);
    sw_raw = 4'h5;
    drain(30);

    // bit0 back to 0, then bounce before settling at 1
    push(4'h4);
    sw_raw = 4'h4;
    drain(30);
    for (int p = 0; p < 8; p++) begin
      sw_raw[0] = (p % 2 == 0);
      repeat (3) @(negedge clk);
    end
    chk("bounce_hold", d_out, 4'h4);
    push(4'h5);
    sw_raw[0] = 1'b1;
    drain(30);

    // bit1 steps cleanly while bit3 bounces
    push(4'h7);
    sw_raw[1] = 1'b1;
    for (int p = 0; p < 8; p++) begin
      sw_raw[3] = (p % 2 == 0);
      repeat (3) @(negedge clk);
    end
    chk("indep_d_out", d_out, 4'h7);
    drain(30);

    // async reset mid-count
    sw_raw = 4'hF;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_d_out", d_out, 0);
    chk("async_changed", changed, 0);
    chk("async_tick", tick, 0);
    @(negedge clk);
    sw_raw = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_discard", d_out, 0);

    // all bits at once
    push(4'hF);
    sw_raw = 4'hF;
    drain(30);

`ifdef SW_DEBOUNCE_EDGE_EN
    push(4'h5);
    sw_raw = 4'h5;
    drain(30);
    push(4'hA);
    sw_raw = 4'hA;
    drain(30);
`endif

    repeat (10) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
